// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock in core-clock cycles, one result per handshake.
// Result appears one edge after the closing meas_clk rise is detected; valid holds until ready.
module clk_period_meter #(
    parameter int CNT_WIDTH = 24,
    parameter int TIMEOUT   = 2**24-1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 meas_clk,
    input  logic                 ready,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 timeout,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] TMO = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_HOLD} state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_hist;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_high_acc;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high_time;
    logic                 r_timeout;
    logic                 r_valid;
    logic                 r_busy;

    logic w_rise;
    logic w_fall;
    logic w_at_tmo;

    assign w_rise   = r_sync2 & ~r_hist;
    assign w_fall   = ~r_sync2 & r_hist;
    assign w_at_tmo = (r_cnt == TMO);

    // Both edges are counted from the same delayed pulses, so synchronizer latency cancels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_hist      <= 1'b0;
            r_cnt       <= '0;
            r_high_acc  <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_timeout   <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync1 <= meas_clk;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (en) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_rise) begin
                        r_cnt      <= CNT_WIDTH'(1);
                        r_high_acc <= '0;
                        r_state    <= S_MEASURE;
                    end else if (w_at_tmo) begin
                        r_period    <= '0;
                        r_high_time <= '0;
                        r_timeout   <= 1'b1;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    // A closing rise on the TIMEOUT cycle still yields a normal result.
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_rise) begin
                        r_period    <= r_cnt;
                        r_high_time <= r_high_acc;
                        r_timeout   <= 1'b0;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_HOLD;
                    end else if (w_at_tmo) begin
                        r_period    <= '0;
                        r_high_time <= '0;
                        r_timeout   <= 1'b1;
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_fall) begin
                            r_high_acc <= r_cnt;
                        end
                    end
                end
                S_HOLD: begin
                    if (ready) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        if (en) begin
                            r_state <= S_ARM;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid     = r_valid;
    assign period    = r_period;
    assign high_time = r_high_time;
    assign timeout   = r_timeout;
    assign busy      = r_busy;

endmodule
